conv_loop_iter: RTL and testbench

//  Loop-nest sequencer for one convolution layer. Steps the index tuple (m,r,c,n,i,j) one term per cycle
//  and feeds it to the address controller. The controller turns each tuple into ifm_addr/weight_addr.

---
 rtl/conv_loop_iter.sv | 140 ++++++++++++++
 tb/tb_conv_loop_iter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_iter.sv
// Loop-nest sequencer for one convolution layer: walks (m,r,c,n,i,j) one MAC term per
// consumed cycle, with start/done handshake, stall hold and per-pixel first/last flags.
module conv_loop_iter #(
  parameter int K        = 5,
  parameter int OUT_SIZE = 28,
  parameter int OUT_CH   = 6,
  parameter int IN_CH    = 1,
  parameter int N_STEP   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stall,
  output logic [7:0] m,
  output logic [7:0] r,
  output logic [7:0] c,
  output logic [7:0] n,
  output logic [3:0] i,
  output logic [3:0] j,
  output logic       valid,
  output logic       pix_first,
  output logic       pix_last,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] IJ_MAX = 4'(K - 1);
  localparam logic [7:0] RC_MAX = 8'(OUT_SIZE - 1);
  localparam logic [7:0] M_MAX  = 8'(OUT_CH - 1);
  localparam logic [7:0] N_MAX  = 8'((IN_CH - 1) * N_STEP);
  localparam logic [7:0] N_INC  = 8'(N_STEP);
  // With one input channel and a 1x1 kernel the very first term also closes its pixel.
  localparam logic FIRST_IS_LAST = (N_MAX == 8'd0) && (IJ_MAX == 4'd0);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic       j_wrap, i_wrap, n_wrap, c_wrap, r_wrap, m_wrap, last_tuple;
  logic [7:0] m_next, r_next, c_next, n_next;
  logic [3:0] i_next, j_next;
  logic       first_next, last_next;

  // Ripple-carry odometer: each field wraps at its maximum and carries outward.
  always_comb begin
    j_wrap = (j == IJ_MAX);
    i_wrap = (i == IJ_MAX);
    n_wrap = (n == N_MAX);
    c_wrap = (c == RC_MAX);
    r_wrap = (r == RC_MAX);
    m_wrap = (m == M_MAX);
    last_tuple = j_wrap && i_wrap && n_wrap && c_wrap && r_wrap && m_wrap;

    j_next = j_wrap ? 4'd0 : j + 4'd1;
    i_next = i;
    n_next = n;
    c_next = c;
    r_next = r;
    m_next = m;
    if (j_wrap) begin
      i_next = i_wrap ? 4'd0 : i + 4'd1;
      if (i_wrap) begin
        n_next = n_wrap ? 8'd0 : n + N_INC;
        if (n_wrap) begin
          c_next = c_wrap ? 8'd0 : c + 8'd1;
          if (c_wrap) begin
            r_next = r_wrap ? 8'd0 : r + 8'd1;
            if (r_wrap) begin
              m_next = m_wrap ? 8'd0 : m + 8'd1;
            end
          end
        end
      end
    end

    first_next = (n_next == 8'd0) && (i_next == 4'd0) && (j_next == 4'd0);
    last_next  = (n_next == N_MAX) && (i_next == IJ_MAX) && (j_next == IJ_MAX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      m         <= '0;
      r         <= '0;
      c         <= '0;
      n         <= '0;
      i         <= '0;
      j         <= '0;
      valid     <= 1'b0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            valid     <= 1'b1;
            busy      <= 1'b1;
            pix_first <= 1'b1;
            pix_last  <= FIRST_IS_LAST;
          end
        end
        RUN: begin
          if (!stall) begin
            if (last_tuple) begin
              state     <= DONE;
              m         <= '0;
              r         <= '0;
              c         <= '0;
              n         <= '0;
              i         <= '0;
              j         <= '0;
              valid     <= 1'b0;
              pix_first <= 1'b0;
              pix_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              m         <= m_next;
              r         <= r_next;
              c         <= c_next;
              n         <= n_next;
              i         <= i_next;
              j         <= j_next;
              pix_first <= first_next;
              pix_last  <= last_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_loop_iter.sv
// Bench for conv_loop_iter: a tiny instance driven from a vector table, the default instance
// for stall/wrap/abort, and a mid-size instance run to completion against a tuple scoreboard.
module tb_conv_loop_iter;

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] r;
    logic [7:0] c;
    logic [7:0] n;
    logic [3:0] i;
    logic [3:0] j;
    logic       valid;
    logic       pf;
    logic       pl;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    logic start;
    logic stall;
    out_t exp;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Small instance: K=2, OUT_SIZE=2, OUT_CH=1, IN_CH=1
  logic rst_s = 1'b1, start_s = 1'b0, stall_s = 1'b0;
  logic [7:0] m_s, r_s, c_s, n_s;
  logic [3:0] i_s, j_s;
  logic valid_s, pf_s, pl_s, busy_s, done_s;
  out_t out_s;
  assign out_s = {m_s, r_s, c_s, n_s, i_s, j_s, valid_s, pf_s, pl_s, busy_s, done_s};

  conv_loop_iter #(.K(2), .OUT_SIZE(2), .OUT_CH(1), .IN_CH(1), .N_STEP(4)) dut_s (
    .clock(clock), .reset(rst_s), .start(start_s), .stall(stall_s),
    .m(m_s), .r(r_s), .c(c_s), .n(n_s), .i(i_s), .j(j_s),
    .valid(valid_s), .pix_first(pf_s), .pix_last(pl_s), .busy(busy_s), .done(done_s));

  // Default instance
  logic rst_d = 1'b1, start_d = 1'b0, stall_d = 1'b0;
  logic [7:0] m_d, r_d, c_d, n_d;
  logic [3:0] i_d, j_d;
  logic valid_d, pf_d, pl_d, busy_d, done_d;
  out_t out_d;
  assign out_d = {m_d, r_d, c_d, n_d, i_d, j_d, valid_d, pf_d, pl_d, busy_d, done_d};

  conv_loop_iter dut_d (
    .clock(clock), .reset(rst_d), .start(start_d), .stall(stall_d),
    .m(m_d), .r(r_d), .c(c_d), .n(n_d), .i(i_d), .j(j_d),
    .valid(valid_d), .pix_first(pf_d), .pix_last(pl_d), .busy(busy_d), .done(done_d));

  // Mid instance: K=3, OUT_SIZE=4, OUT_CH=3, IN_CH=2, N_STEP=4 -> 864 terms
  logic rst_x = 1'b1, start_x = 1'b0, stall_x = 1'b0;
  logic [7:0] m_x, r_x, c_x, n_x;
  logic [3:0] i_x, j_x;
  logic valid_x, pf_x, pl_x, busy_x, done_x;
  out_t out_x;
  assign out_x = {m_x, r_x, c_x, n_x, i_x, j_x, valid_x, pf_x, pl_x, busy_x, done_x};

  conv_loop_iter #(.K(3), .OUT_SIZE(4), .OUT_CH(3), .IN_CH(2), .N_STEP(4)) dut_x (
    .clock(clock), .reset(rst_x), .start(start_x), .stall(stall_x),
    .m(m_x), .r(r_x), .c(c_x), .n(n_x), .i(i_x), .j(j_x),
    .valid(valid_x), .pix_first(pf_x), .pix_last(pl_x), .busy(busy_x), .done(done_x));

  localparam int DK = 5, DOS = 28, DIC = 1, DNS = 4;
  localparam int XTOTAL = 3 * 4 * 4 * 2 * 3 * 3;

  out_t sb_q[$];
  int em, er, ec, en, ei, ej;

  function automatic out_t mk(int mm, int rr, int cc, int nn, int ii, int jj,
                              bit v, bit pf, bit pl, bit b, bit d);
    out_t o;
    o.m = 8'(mm); o.r = 8'(rr); o.c = 8'(cc); o.n = 8'(nn);
    o.i = 4'(ii); o.j = 4'(jj);
    o.valid = v; o.pf = pf; o.pl = pl; o.busy = b; o.done = d;
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic out_t model_d();
    return mk(em, er, ec, en, ei, ej, 1'b1,
              (en == 0) && (ei == 0) && (ej == 0),
              (en == (DIC - 1) * DNS) && (ei == DK - 1) && (ej == DK - 1), 1'b1, 1'b0);
  endfunction

  task automatic model_adv();
    ej++;
    if (ej == DK) begin
      ej = 0; ei++;
      if (ei == DK) begin
        ei = 0; en += DNS;
        if (en > (DIC - 1) * DNS) begin
          en = 0; ec++;
          if (ec == DOS) begin
            ec = 0; er++;
            if (er == DOS) begin er = 0; em++; end
          end
        end
      end
    end
  endtask

  // Called at a negedge showing the current tuple; checks and consumes nsteps tuples.
  task automatic step_d(input int nsteps);
    for (int k = 0; k < nsteps; k++) begin
      check("run_d", out_d, model_d());
      stall_d = 1'b0;
      model_adv();
      @(negedge clock);
    end
  endtask

  task automatic start_pass_d();
    start_d = 1'b1;
    @(negedge clock);
    start_d = 1'b0;
    em = 0; er = 0; ec = 0; en = 0; ei = 0; ej = 0;
  endtask

  initial begin
    vec_t vt[19];
    int idx;
    int consumed, dones, hold_last;
    bit fin, expect_done;
    out_t zero_o, hold_o;
    zero_o = '0;

    // Reset then idle
    #1;
    check("reset_async", out_d, zero_o);
    repeat (3) @(negedge clock);
    rst_s = 1'b0; rst_d = 1'b0; rst_x = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("idle_d", out_d, zero_o);
    end

    // Small pass from a vector table
    vt[0].start = 1'b1; vt[0].stall = 1'b0; vt[0].exp = zero_o;
    idx = 1;
    for (int rr = 0; rr < 2; rr++)
      for (int cc = 0; cc < 2; cc++)
        for (int ii = 0; ii < 2; ii++)
          for (int jj = 0; jj < 2; jj++) begin
            vt[idx].start = 1'b0;
            vt[idx].stall = 1'b0;
            vt[idx].exp = mk(0, rr, cc, 0, ii, jj, 1'b1, (ii == 0) && (jj == 0),
                             (ii == 1) && (jj == 1), 1'b1, 1'b0);
            idx++;
          end
    vt[5].start = 1'b1;
    vt[17].start = 1'b1; vt[17].stall = 1'b0;
    vt[17].exp = mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    vt[18].start = 1'b0; vt[18].stall = 1'b0; vt[18].exp = zero_o;
    for (int k = 0; k < 19; k++) begin
      @(negedge clock);
      check($sformatf("small_vec%0d", k), out_s, vt[k].exp);
      start_s = vt[k].start;
      stall_s = vt[k].stall;
    end
    start_s = 1'b0;

    // Default pass A: stall hold at tuple 14, then abort at tuple 500
    @(negedge clock);
    start_pass_d();
    step_d(14);
    hold_o = mk(0, 0, 0, 0, 2, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("stall_pre", out_d, hold_o);
    stall_d = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("stall_hold", out_d, hold_o);
    end
    stall_d = 1'b0;
    @(negedge clock);
    check("after_stall", out_d, mk(0, 0, 0, 0, 3, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    model_adv();
    step_d(485);
    check("tuple500", out_d, mk(0, 0, 20, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    rst_d = 1'b1;
    #1;
    check("abort_now", out_d, zero_o);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("abort_hold", out_d, zero_o);
    end
    rst_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("abort_no_done", out_d, zero_o);
    end

    // Default pass B: restart from zero, then c/r carry
    start_pass_d();
    check("restart", out_d, mk(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    step_d(699);
    check("pre_wrap", out_d, mk(0, 0, 27, 0, 4, 4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    stall_d = 1'b0;
    @(negedge clock);
    check("wrap", out_d, mk(0, 1, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    rst_d = 1'b1;
    @(negedge clock);
    rst_d = 1'b0;

    // Mid pass: full run with random stalls and ignored start pulses
    start_x = 1'b1;
    for (int mm = 0; mm < 3; mm++)
      for (int rr = 0; rr < 4; rr++)
        for (int cc = 0; cc < 4; cc++)
          for (int nn = 0; nn < 2; nn++)
            for (int ii = 0; ii < 3; ii++)
              for (int jj = 0; jj < 3; jj++)
                sb_q.push_back(mk(mm, rr, cc, nn * 4, ii, jj, 1'b1,
                                  (nn == 0) && (ii == 0) && (jj == 0),
                                  (nn == 1) && (ii == 2) && (jj == 2), 1'b1, 1'b0));
    @(negedge clock);
    start_x = 1'b0;
    consumed = 0; dones = 0; hold_last = 0; fin = 1'b0; expect_done = 1'b0;
    for (int cyc = 0; cyc < 4 * XTOTAL && !fin; cyc++) begin
      if (expect_done) begin
        check_val("done_after_last", int'(out_x.done), 1);
        expect_done = 1'b0;
      end
      if (out_x.done) begin
        dones++;
        fin = 1'b1;
        check("done_state", out_x, mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        start_x = 1'b1;
      end else if (out_x.valid) begin
        if (sb_q.size() == 0) begin
          check_val("extra_tuple", sb_q.size(), 1);
          fin = 1'b1;
        end else begin
          check("sb_tuple", out_x, sb_q[0]);
          if (sb_q.size() == 1 && hold_last < 3) begin
            stall_x = 1'b1;
            hold_last++;
          end else begin
            stall_x = ($urandom_range(0, 3) == 0);
          end
          start_x = (sb_q.size() > 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
          if (!stall_x) begin
            void'(sb_q.pop_front());
            consumed++;
            if (sb_q.size() == 0) expect_done = 1'b1;
          end
        end
      end else begin
        check("mid_unexpected_idle", out_x, mk(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        fin = 1'b1;
      end
      @(negedge clock);
    end
    start_x = 1'b0;
    stall_x = 1'b0;
    check_val("mid_finished", int'(fin), 1);
    check_val("mid_consumed", consumed, XTOTAL);
    check_val("mid_done_pulses", dones, 1);
    for (int k = 0; k < 3; k++) begin
      check("mid_idle_after", out_x, zero_o);
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
